st_padding_cfg_sequencer: RTL and testbench

//  Store-side layer controller for the block-padding unit. Accepts one layer descriptor per handshake.

---
 rtl/st_padding_cfg_sequencer_pkg.sv | 39 +++
 rtl/st_padding_cfg_sequencer_watchdog.sv | 41 ++++
 rtl/st_padding_cfg_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_st_padding_cfg_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/st_padding_cfg_sequencer_pkg.sv
// Shared definitions for the store-side padding config sequencer.
// Contents:
//   state_t      - sequencer FSM state encoding (3 bits)
//   BEAT_*       - beat-kind codes, numbered in upsample beat order
//   beat_count   - number of loop-config beats for a layer
//   beat_kind    - beat index to beat kind, for both layer shapes
package st_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAD     = 3'd1,
    S_BEATS   = 3'd2,
    S_RESTART = 3'd3,
    S_RUN     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [2:0] BEAT_UPDOWN = 3'd0;
  localparam logic [2:0] BEAT_UP_R   = 3'd1;
  localparam logic [2:0] BEAT_UP_L   = 3'd2;
  localparam logic [2:0] BEAT_W      = 3'd3;
  localparam logic [2:0] BEAT_H      = 3'd4;
  localparam logic [2:0] BEAT_OC     = 3'd5;
  localparam logic [2:0] BEAT_B      = 3'd6;
  localparam logic [2:0] BEAT_ST1    = 3'd7;

  function automatic logic [3:0] beat_count(input logic upsample, input logic st1);
    return 4'd5 + {2'b00, upsample, 1'b0} + {3'b000, st1};
  endfunction

  // Kinds are numbered in upsample order, so with upsample the index is the
  // kind. Without upsample the two [1,1] beats are skipped, shifting every
  // beat after updown up by two.
  function automatic logic [2:0] beat_kind(input logic [2:0] idx, input logic upsample);
    if (upsample || (idx == 3'd0)) return idx;
    return idx + 3'd2;
  endfunction

endpackage

// File: rtl/st_padding_cfg_sequencer_watchdog.sv
// Run-phase stall watchdog.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   enable      counting allowed (sequencer in RUN and layer not finishing)
//   activity    store data beat; restarts the idle count
//   clear       drops the sticky timeout (new descriptor accepted)
//   timeout     sticky flag, set when the idle count reaches all-ones
module st_run_watchdog #(
  parameter int TIMEOUT_W = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic activity,
  input  logic clear,
  output logic timeout
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] CNT_PRE = CNT_MAX - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] count;

  // The flag is raised on the same edge that the count reaches all-ones, and
  // the count then saturates so a long stall cannot wrap back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      if (clear) timeout <= 1'b0;
      if (!enable || activity) begin
        count <= '0;
      end else if (count != CNT_MAX) begin
        count <= count + 1'b1;
        if (count == CNT_PRE) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/st_padding_cfg_sequencer.sv
// Store-side layer controller for the block-padding unit.
// Accepts one layer descriptor per handshake, emits a pad-config pulse,
// replays the loop-iteration beats on the store loop-config bus, pulses the
// address-counter restart, then supervises the run until all_done.
// Ports:
//   desc_*               descriptor handshake and fields from the controller
//   cfg_ready            loop-config bus back-pressure
//   cfg_block_padding_v  pad-config pulse; diff_rows / upsample_required held
//   cfg_loop_iter_st*    loop-iter beat stream (st1 marker on its own valid)
//   st_addr_valid_pd     address-counter restart pulse
//   data_valid, all_done run-phase activity and completion
//   busy, layer_done, desc_err, timeout  status
module st_padding_cfg_sequencer
  import st_cfg_pkg::*;
#(
  parameter int IMM_WIDTH   = 16,
  parameter int LOOP_ITER_W = 16,
  parameter int TIMEOUT_W   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [LOOP_ITER_W-1:0] desc_width,
  input  logic [LOOP_ITER_W-1:0] desc_height,
  input  logic [LOOP_ITER_W-1:0] desc_oc,
  input  logic [LOOP_ITER_W-1:0] desc_batch,
  input  logic [LOOP_ITER_W-1:0] desc_updown,
  input  logic [IMM_WIDTH-1:0]   desc_diff_rows,
  input  logic                   desc_upsample,
  input  logic                   desc_st1,
  input  logic                   cfg_ready,
  output logic                   cfg_block_padding_v,
  output logic [IMM_WIDTH-1:0]   diff_rows,
  output logic                   upsample_required,
  output logic                   cfg_loop_iter_st_v,
  output logic                   cfg_loop_iter_st1_v,
  output logic [LOOP_ITER_W-1:0] cfg_loop_iter_st,
  output logic                   st_addr_valid_pd,
  input  logic                   data_valid,
  input  logic                   all_done,
  output logic                   busy,
  output logic                   layer_done,
  output logic                   desc_err,
  output logic                   timeout
);

  localparam int CMP_W = (IMM_WIDTH > LOOP_ITER_W) ? IMM_WIDTH : LOOP_ITER_W;
  localparam logic [LOOP_ITER_W-1:0] ONE = LOOP_ITER_W'(1);

  state_t                 state;
  logic [2:0]             beat_idx;
  logic [LOOP_ITER_W-1:0] lat_width, lat_height, lat_oc, lat_batch, lat_updown;
  logic                   lat_st1;

  logic                   accept;
  logic                   desc_bad;
  logic [CMP_W-1:0]       diff_ext, height_ext;
  logic [2:0]             load_idx, load_kind;
  logic [LOOP_ITER_W-1:0] load_value;
  logic                   last_beat;
  logic                   run_enable;

  assign desc_ready = (state == S_IDLE) && !reset;
  assign accept     = desc_valid && desc_ready;
  assign busy       = (state != S_IDLE);
  // all_done takes priority over the watchdog in the finishing cycle.
  assign run_enable = (state == S_RUN) && !all_done;

  // Descriptor legality, plus the beat to present next: beat 0 when leaving
  // PAD, otherwise the successor of the beat currently on the bus. Counts
  // are minus-one encoded; zero counts never reach here, so nothing wraps.
  always_comb begin
    diff_ext   = CMP_W'(desc_diff_rows);
    height_ext = CMP_W'(desc_height);
    desc_bad   = (desc_width == '0) || (desc_height == '0) || (desc_oc == '0) ||
                 (desc_batch == '0) || (diff_ext >= height_ext);
    load_idx   = (state == S_PAD) ? 3'd0 : beat_idx + 3'd1;
    load_kind  = beat_kind(load_idx, upsample_required);
    load_value = '0;
    case (load_kind)
      BEAT_UPDOWN:          load_value = lat_updown;
      BEAT_UP_R, BEAT_UP_L: load_value = ONE;
      BEAT_W:               load_value = lat_width - ONE;
      BEAT_H:               load_value = lat_height - ONE;
      BEAT_OC:              load_value = lat_oc - ONE;
      BEAT_B:               load_value = lat_batch - ONE;
      default:              load_value = '0;
    endcase
    last_beat = ({1'b0, beat_idx} == (beat_count(upsample_required, lat_st1) - 4'd1));
  end

  // Sequencer FSM with registered outputs. Pulse outputs default low each
  // cycle; a beat's valid and value only change on its own handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      beat_idx            <= '0;
      lat_width           <= '0;
      lat_height          <= '0;
      lat_oc              <= '0;
      lat_batch           <= '0;
      lat_updown          <= '0;
      lat_st1             <= 1'b0;
      diff_rows           <= '0;
      upsample_required   <= 1'b0;
      cfg_block_padding_v <= 1'b0;
      cfg_loop_iter_st_v  <= 1'b0;
      cfg_loop_iter_st1_v <= 1'b0;
      cfg_loop_iter_st    <= '0;
      st_addr_valid_pd    <= 1'b0;
      layer_done          <= 1'b0;
      desc_err            <= 1'b0;
    end else begin
      cfg_block_padding_v <= 1'b0;
      st_addr_valid_pd    <= 1'b0;
      layer_done          <= 1'b0;
      desc_err            <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_width         <= desc_width;
            lat_height        <= desc_height;
            lat_oc            <= desc_oc;
            lat_batch         <= desc_batch;
            lat_updown        <= desc_updown;
            lat_st1           <= desc_st1;
            diff_rows         <= desc_diff_rows;
            upsample_required <= desc_upsample;
            if (desc_bad) begin
              desc_err <= 1'b1;
            end else begin
              state               <= S_PAD;
              cfg_block_padding_v <= 1'b1;
            end
          end
        end
        S_PAD: begin
          state               <= S_BEATS;
          beat_idx            <= load_idx;
          cfg_loop_iter_st    <= load_value;
          cfg_loop_iter_st_v  <= (load_kind != BEAT_ST1);
          cfg_loop_iter_st1_v <= (load_kind == BEAT_ST1);
        end
        S_BEATS: begin
          if (cfg_ready) begin
            if (last_beat) begin
              state               <= S_RESTART;
              cfg_loop_iter_st    <= '0;
              cfg_loop_iter_st_v  <= 1'b0;
              cfg_loop_iter_st1_v <= 1'b0;
              st_addr_valid_pd    <= 1'b1;
            end else begin
              beat_idx            <= load_idx;
              cfg_loop_iter_st    <= load_value;
              cfg_loop_iter_st_v  <= (load_kind != BEAT_ST1);
              cfg_loop_iter_st1_v <= (load_kind == BEAT_ST1);
            end
          end
        end
        S_RESTART: state <= S_RUN;
        S_RUN: begin
          if (all_done) begin
            state      <= S_DONE;
            layer_done <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  st_run_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .enable  (run_enable),
    .activity(data_valid),
    .clear   (accept),
    .timeout (timeout)
  );

endmodule

// File: tb/tb_st_padding_cfg_sequencer.sv
// Self-checking bench for st_padding_cfg_sequencer (watchdog shortened to
// TIMEOUT_W=4 so a stall limit of 15 cycles is reachable).
module tb_st_padding_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        desc_valid, desc_ready;
  logic [15:0] desc_width, desc_height, desc_oc, desc_batch, desc_updown, desc_diff_rows;
  logic        desc_upsample, desc_st1, cfg_ready;
  logic        cfg_block_padding_v, upsample_required;
  logic [15:0] diff_rows, cfg_loop_iter_st;
  logic        cfg_loop_iter_st_v, cfg_loop_iter_st1_v, st_addr_valid_pd;
  logic        data_valid, all_done, busy, layer_done, desc_err, timeout;

  int nChecks = 0;
  int nPass   = 0;

  logic [15:0] expBeats [8];

  typedef struct {
    logic        dv;
    logic [15:0] w, h, oc, b, ud, diff;
    logic        up, st1, cr, dvl, ad;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  st_padding_cfg_sequencer #(
    .IMM_WIDTH  (16),
    .LOOP_ITER_W(16),
    .TIMEOUT_W  (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .desc_valid         (desc_valid),
    .desc_ready         (desc_ready),
    .desc_width         (desc_width),
    .desc_height        (desc_height),
    .desc_oc            (desc_oc),
    .desc_batch         (desc_batch),
    .desc_updown        (desc_updown),
    .desc_diff_rows     (desc_diff_rows),
    .desc_upsample      (desc_upsample),
    .desc_st1           (desc_st1),
    .cfg_ready          (cfg_ready),
    .cfg_block_padding_v(cfg_block_padding_v),
    .diff_rows          (diff_rows),
    .upsample_required  (upsample_required),
    .cfg_loop_iter_st_v (cfg_loop_iter_st_v),
    .cfg_loop_iter_st1_v(cfg_loop_iter_st1_v),
    .cfg_loop_iter_st   (cfg_loop_iter_st),
    .st_addr_valid_pd   (st_addr_valid_pd),
    .data_valid         (data_valid),
    .all_done           (all_done),
    .busy               (busy),
    .layer_done         (layer_done),
    .desc_err           (desc_err),
    .timeout            (timeout)
  );

  // Expected-output word: {ready, busy, pad, st_v, st1_v, restart, done, err, timeout, value}
  function automatic logic [24:0] ex(input int rdy, input int bsy, input int pad, input int stv,
                                     input int st1v, input int addr, input int ld, input int err,
                                     input int to, input int val);
    return {rdy[0], bsy[0], pad[0], stv[0], st1v[0], addr[0], ld[0], err[0], to[0], 16'(val)};
  endfunction

  function automatic vec_t mkv(input int dv, input int w, input int h, input int oc, input int b,
                               input int ud, input int diff, input int up, input int st1,
                               input int cr, input int dvl, input int ad, input logic [24:0] e);
    vec_t v;
    v.dv = dv[0]; v.w = 16'(w); v.h = 16'(h); v.oc = 16'(oc); v.b = 16'(b);
    v.ud = 16'(ud); v.diff = 16'(diff); v.up = up[0]; v.st1 = st1[0];
    v.cr = cr[0]; v.dvl = dvl[0]; v.ad = ad[0]; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setDesc(input int w, input int h, input int oc, input int b, input int ud,
                         input int diff, input int up, input int st1);
    desc_width = 16'(w); desc_height = 16'(h); desc_oc = 16'(oc); desc_batch = 16'(b);
    desc_updown = 16'(ud); desc_diff_rows = 16'(diff);
    desc_upsample = up[0]; desc_st1 = st1[0];
  endtask

  task automatic checkOutput(input string name, input logic [24:0] exp);
    logic [24:0] act;
    act = {desc_ready, busy, cfg_block_padding_v, cfg_loop_iter_st_v, cfg_loop_iter_st1_v,
           st_addr_valid_pd, layer_done, desc_err, timeout, cfg_loop_iter_st};
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got flags=%b val=%0d, expected flags=%b val=%0d",
                  name, act[24:16], act[15:0], exp[24:16], exp[15:0]);
  endtask

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    desc_valid = v.dv;
    setDesc(int'(v.w), int'(v.h), int'(v.oc), int'(v.b), int'(v.ud), int'(v.diff),
            int'(v.up), int'(v.st1));
    cfg_ready = v.cr; data_valid = v.dvl; all_done = v.ad;
    tick();
  endtask

  // Offer a descriptor, check the pad pulse and held fields, then step to beat 0.
  task automatic acceptAndPad(input string nm, input int w, input int h, input int oc, input int b,
                              input int ud, input int diff, input int up, input int st1,
                              input int keep);
    setDesc(w, h, oc, b, ud, diff, up, st1);
    desc_valid = 1'b1; cfg_ready = 1'b1; data_valid = 1'b0; all_done = 1'b0;
    tick();
    checkOutput({nm, "_pad"}, ex(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    checkVal({nm, "_diff_rows"}, diff_rows, 16'(diff));
    checkVal({nm, "_upsample"}, {15'd0, upsample_required}, 16'(up));
    if (keep == 0) desc_valid = 1'b0;
    tick();
  endtask

  // Walk the beats in expBeats, optionally stalling cfg_ready, then check restart.
  task automatic checkBeatSeq(input string nm, input int n, input int hasSt1,
                              input int stallAt, input int stallN);
    for (int i = 0; i < n; i++) begin
      int isSt1;
      isSt1 = (hasSt1 != 0 && i == n - 1) ? 1 : 0;
      if (i == stallAt) begin
        cfg_ready = 1'b0;
        for (int s = 0; s < stallN; s++) begin
          checkOutput($sformatf("%s_stall%0d", nm, s),
                      ex(0, 1, 0, 1 - isSt1, isSt1, 0, 0, 0, 0, int'(expBeats[i])));
          tick();
        end
      end
      checkOutput($sformatf("%s_beat%0d", nm, i),
                  ex(0, 1, 0, 1 - isSt1, isSt1, 0, 0, 0, 0, int'(expBeats[i])));
      cfg_ready = 1'b1;
      tick();
    end
    checkOutput({nm, "_restart"}, ex(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
  endtask

  // all_done is already high on the first RUN cycle.
  task automatic finishLayer(input string nm);
    all_done = 1'b1;
    tick();
    checkOutput({nm, "_run"}, ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkOutput({nm, "_done"}, ex(0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    all_done = 1'b0;
    tick();
    checkOutput({nm, "_idle"}, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_time_limit: simulation did not complete");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    reset = 1'b1; desc_valid = 1'b0; cfg_ready = 1'b0; data_valid = 1'b0; all_done = 1'b0;
    setDesc(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    tick(); tick();
    checkOutput("reset_outputs", ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkVal("reset_diff_rows", diff_rows, 16'd0);
    reset = 1'b0;
    #1;
    checkOutput("reset_release", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Plain layer w=8 h=6 oc=4 b=1 updown=1 diff=2, then illegal descriptors
    vecs.push_back(mkv(1, 8, 6, 4, 1, 1, 2, 0, 0, 1, 0, 0, ex(0, 1, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mkv(0, 8, 6, 4, 1, 1, 2, 0, 0, 1, 0, 0, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(mkv(0, 8, 6, 4, 1, 1, 2, 0, 0, 1, 0, 0, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 7)));
    vecs.push_back(mkv(0, 8, 6, 4, 1, 1, 2, 0, 0, 1, 0, 0, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 5)));
    vecs.push_back(mkv(0, 8, 6, 4, 1, 1, 2, 0, 0, 1, 0, 0, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 3)));
    vecs.push_back(mkv(0, 8, 6, 4, 1, 1, 2, 0, 0, 1, 0, 0, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mkv(0, 8, 6, 4, 1, 1, 2, 0, 0, 1, 0, 0, ex(0, 1, 0, 0, 0, 1, 0, 0, 0, 0)));
    vecs.push_back(mkv(0, 8, 6, 4, 1, 1, 2, 0, 0, 1, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mkv(0, 8, 6, 4, 1, 1, 2, 0, 0, 1, 0, 1, ex(0, 1, 0, 0, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(mkv(0, 8, 6, 4, 1, 1, 2, 0, 0, 1, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mkv(1, 8, 4, 4, 1, 1, 4, 0, 0, 1, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkv(1, 8, 4, 0, 1, 1, 0, 0, 0, 1, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkv(0, 8, 4, 0, 1, 1, 0, 0, 0, 1, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Upsample + st1 layer with cfg_ready stalled for 3 cycles on beat 2
    $display("[TB] upsample+st1 layer");
    acceptAndPad("up", 10, 12, 3, 2, 5, 0, 1, 1, 0);
    expBeats = '{16'd5, 16'd1, 16'd1, 16'd9, 16'd11, 16'd2, 16'd1, 16'd0};
    checkBeatSeq("up", 8, 1, 1, 3);
    finishLayer("up");

    // RUN stall: no data_valid for 20 cycles, then all_done
    $display("[TB] run stall");
    acceptAndPad("stall", 2, 2, 1, 1, 0, 0, 0, 0, 0);
    expBeats = '{16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    checkBeatSeq("stall", 5, 0, -1, 0);
    data_valid = 1'b0; all_done = 1'b0;
    tick();
    checkOutput("stall_run0", ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("stall_idle%0d", k),
                  ex(0, 1, 0, 0, 0, 0, 0, 0, (k >= 15) ? 1 : 0, 0));
    end
    all_done = 1'b1;
    tick();
    checkOutput("stall_done", ex(0, 1, 0, 0, 0, 0, 1, 0, 1, 0));
    all_done = 1'b0;
    tick();
    checkOutput("stall_idle_sticky", ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Reset asserted during beat 3, then a fresh layer
    $display("[TB] reset mid-sequence");
    acceptAndPad("rst", 8, 6, 4, 1, 1, 2, 0, 0, 0);
    checkOutput("rst_beat0", ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    tick();
    tick();
    checkOutput("rst_beat2", ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 5));
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async", ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); tick();
    checkOutput("rst_held", ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkVal("rst_diff_rows", diff_rows, 16'd0);
    checkVal("rst_upsample", {15'd0, upsample_required}, 16'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_release", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    acceptAndPad("post", 3, 5, 2, 1, 2, 1, 1, 0, 0);
    expBeats = '{16'd2, 16'd1, 16'd1, 16'd2, 16'd4, 16'd1, 16'd0, 16'd0};
    checkBeatSeq("post", 7, 0, -1, 0);
    finishLayer("post");

    // Back-to-back descriptors with desc_valid held high
    $display("[TB] back-to-back");
    acceptAndPad("b2bA", 4, 4, 1, 1, 0, 1, 0, 0, 1);
    setDesc(5, 7, 2, 3, 4, 3, 0, 1);
    expBeats = '{16'd0, 16'd3, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    checkBeatSeq("b2bA", 5, 0, -1, 0);
    tick();
    checkOutput("b2bA_run", ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 21; k++) begin
      data_valid = (k == 10) ? 1'b1 : 1'b0;
      tick();
      checkOutput($sformatf("b2bA_active%0d", k), ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    data_valid = 1'b1; all_done = 1'b1;
    tick();
    checkOutput("b2bA_done", ex(0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    checkVal("b2bA_done_diff", diff_rows, 16'd1);
    data_valid = 1'b0; all_done = 1'b0;
    tick();
    checkOutput("b2bA_idle", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkVal("b2bA_idle_diff", diff_rows, 16'd1);
    tick();
    checkOutput("b2bB_pad", ex(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    checkVal("b2bB_diff", diff_rows, 16'd3);
    desc_valid = 1'b0;
    tick();
    expBeats = '{16'd4, 16'd4, 16'd6, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0};
    checkBeatSeq("b2bB", 6, 1, -1, 0);
    finishLayer("b2bB");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
